// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle for sub_serial: operand channel in, result channel out.
interface sub_serial_if #(parameter int WIDTH = 6);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, overflow
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial signed subtractor (a - b, LSB first, one bit per cycle) with valid/ready handshakes.
// Define SUB_SERIAL_SAT_EN to saturate diff on overflow instead of wrapping.
module sub_serial #(
  parameter int WIDTH = 6
) (
  input logic         clk,
  input logic         rst_n,
  sub_serial_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_raw;
  logic [WIDTH-1:0] r_diff;
  logic             r_c;
  logic             r_ovf;
  logic             r_inReady;
  logic             r_outValid;

  logic             w_aBit;
  logic             w_nbBit;
  logic             w_sum;
  logic             w_cOut;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_result;

  // Subtraction as a + ~b + 1: the +1 comes from the carry being preset to 1 on accept.
  assign w_aBit  = r_a[r_cnt];
  assign w_nbBit = ~r_b[r_cnt];
  assign w_sum   = w_aBit ^ w_nbBit ^ r_c;
  assign w_cOut  = (w_aBit & w_nbBit) | (w_aBit & r_c) | (w_nbBit & r_c);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_ovf   = r_c ^ w_cOut;

  always_comb begin
    w_raw            = r_raw;
    w_raw[WIDTH-1]   = w_sum;
  end

`ifdef SUB_SERIAL_SAT_EN
  logic [WIDTH-1:0] w_sat;
  assign w_sat    = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign w_result = w_ovf ? w_sat : w_raw;
`else
  assign w_result = w_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_raw      <= '0;
      r_c        <= 1'b0;
      r_diff     <= '0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_c       <= 1'b1;
            r_cnt     <= '0;
            r_state   <= RUN;
            r_inReady <= 1'b0;
          end
        end
        RUN: begin
          r_raw[r_cnt] <= w_sum;
          r_c          <= w_cOut;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff     <= w_result;
            r_ovf      <= w_ovf;
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
        end
        DONE: begin
          // Result stays registered until the consumer takes it.
          if (bus.out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.diff      = r_diff;
  assign bus.overflow  = r_ovf;
endmodule
